// File: rtl/xoodoo_sca_ctrl.sv
// rtl/xoodoo_sca_ctrl.sv - command sequencer for a masked two-share Xoodoo permutation core
module xoodoo_sca_ctrl #(
   parameter int NWORDS  = 12,
   parameter int TIMEOUT = 4096
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic [3:0]  cmd_flags_i,
   input  logic [31:0] cmd_domain_i,
   input  logic        cmd_dom_en_i,
   input  logic        din_valid_i,
   output logic        din_ready_o,
   input  logic [63:0] din_data_i,
   output logic        dout_valid_o,
   input  logic        dout_ready_i,
   output logic [63:0] dout_data_o,
   input  logic        rnd_valid_i,
   output logic        xd_init_o,
   output logic        xd_start_o,
   output logic        xd_word_enable_o,
   output logic        xd_domain_enable_o,
   output logic        xd_rdi_valid_o,
   output logic [63:0] xd_word_o,
   output logic [3:0]  xd_word_index_o,
   output logic [31:0] xd_domain_o,
   input  logic [63:0] xd_word_i,
   input  logic        xd_state_valid_i,
   input  logic        xd_rdi_ready_i,
   output logic        busy_o,
   output logic        err_o
);
   localparam int             CW       = $clog2(TIMEOUT + 1);
   localparam logic [3:0]     LAST_IDX = 4'(NWORDS - 1);
   localparam logic [CW-1:0]  TMO_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, INIT, LOAD, DOM, ARM, RUN, READ, ERR} state_e;

   state_e        state_q, state_d;
   logic [3:0]    flags_q, flags_d;
   logic          dom_en_q, dom_en_d;
   logic [31:0]   domain_q, domain_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [CW-1:0] cyc_q, cyc_d;
   logic          err_q, err_d;
   logic          live_q;
   logic          cmd_fire;

   // First enabled phase at or after position pos: 0 INIT, 1 LOAD, 2 DOM, 3 ARM, 4 READ.
   function automatic state_e first_phase(input logic [2:0] pos, input logic [3:0] fl,
                                          input logic de);
      state_e s;
      if (pos == 3'd0 && fl[0])       s = INIT;
      else if (pos <= 3'd1 && fl[1])  s = LOAD;
      else if (pos <= 3'd2 && de)     s = DOM;
      else if (pos <= 3'd3 && fl[2])  s = ARM;
      else if (pos <= 3'd4 && fl[3])  s = READ;
      else                            s = IDLE;
      return s;
   endfunction

   // live_q keeps cmd_ready_o low until the first edge after reset release.
   assign cmd_ready_o = live_q && (state_q == IDLE) && !err_q;
   assign cmd_fire    = cmd_valid_i && cmd_ready_o;
   assign busy_o      = (state_q != IDLE);
   assign err_o       = err_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         flags_q  <= '0;
         dom_en_q <= 1'b0;
         domain_q <= '0;
         cnt_q    <= '0;
         cyc_q    <= '0;
         err_q    <= 1'b0;
         live_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         flags_q  <= flags_d;
         dom_en_q <= dom_en_d;
         domain_q <= domain_d;
         cnt_q    <= cnt_d;
         cyc_q    <= cyc_d;
         err_q    <= err_d;
         live_q   <= 1'b1;
      end
   end

   always_comb begin
      state_d            = state_q;
      flags_d            = flags_q;
      dom_en_d           = dom_en_q;
      domain_d           = domain_q;
      cnt_d              = cnt_q;
      cyc_d              = cyc_q;
      err_d              = err_q;
      din_ready_o        = 1'b0;
      dout_valid_o       = 1'b0;
      dout_data_o        = '0;
      xd_init_o          = 1'b0;
      xd_start_o         = 1'b0;
      xd_word_enable_o   = 1'b0;
      xd_domain_enable_o = 1'b0;
      xd_rdi_valid_o     = 1'b0;
      xd_word_o          = '0;
      xd_word_index_o    = '0;
      xd_domain_o        = '0;
      case (state_q)
         IDLE: begin
            if (cmd_fire) begin
               flags_d  = cmd_flags_i;
               dom_en_d = cmd_dom_en_i;
               domain_d = cmd_domain_i;
               cnt_d    = '0;
               state_d  = (cmd_flags_i == 4'd0) ? IDLE
                          : first_phase(3'd0, cmd_flags_i, cmd_dom_en_i);
            end
         end
         INIT: begin
            xd_init_o = 1'b1;
            state_d   = first_phase(3'd1, flags_q, dom_en_q);
         end
         LOAD: begin
            din_ready_o     = 1'b1;
            xd_word_index_o = cnt_q;
            if (din_valid_i) begin
               xd_word_enable_o = 1'b1;
               xd_word_o        = din_data_i;
               if (cnt_q == LAST_IDX) begin
                  cnt_d   = '0;
                  state_d = first_phase(3'd2, flags_q, dom_en_q);
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
         end
         DOM: begin
            xd_domain_enable_o = 1'b1;
            xd_domain_o        = domain_q;
            state_d            = first_phase(3'd3, flags_q, dom_en_q);
         end
         ARM: begin
            xd_rdi_valid_o = rnd_valid_i;
            if (rnd_valid_i) begin
               xd_start_o = 1'b1;
               cyc_d      = '0;
               state_d    = RUN;
            end
         end
         RUN: begin
            xd_rdi_valid_o = rnd_valid_i;
            cyc_d          = cyc_q + CW'(1);
            // A request without fresh randomness means the core ran on zeroed masks.
            if (xd_rdi_ready_i && !rnd_valid_i) begin
               err_d   = 1'b1;
               state_d = ERR;
            end else if (xd_state_valid_i) begin
               cyc_d   = '0;
               state_d = first_phase(3'd4, flags_q, dom_en_q);
            end else if (cyc_q == TMO_LAST) begin
               err_d   = 1'b1;
               state_d = ERR;
            end
         end
         READ: begin
            xd_word_index_o = cnt_q;
            dout_valid_o    = 1'b1;
            dout_data_o     = xd_word_i;
            if (dout_ready_i) begin
               if (cnt_q == LAST_IDX) begin
                  cnt_d   = '0;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
         end
         ERR: begin
            err_d = 1'b1;
         end
         default: begin
            state_d = ERR;
         end
      endcase
   end
endmodule

// File: tb/tb_xoodoo_sca_ctrl.sv
// tb/tb_xoodoo_sca_ctrl.sv - directed self-checking bench for xoodoo_sca_ctrl
module tb_xoodoo_sca_ctrl;
   localparam int NWORDS  = 12;
   localparam int TIMEOUT = 4096;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid, cmd_dom_en, din_valid, dout_ready, rnd_valid;
   logic [3:0]  cmd_flags;
   logic [31:0] cmd_domain;
   logic [63:0] din_data;
   logic        xd_state_valid, xd_rdi_ready;
   logic [63:0] xd_word_i;
   logic        cmd_ready_o, din_ready_o, dout_valid_o;
   logic [63:0] dout_data_o, xd_word_o;
   logic        xd_init_o, xd_start_o, xd_word_enable_o, xd_domain_enable_o, xd_rdi_valid_o;
   logic [3:0]  xd_word_index_o;
   logic [31:0] xd_domain_o;
   logic        busy_o, err_o;
   logic [173:0] all_out;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Core model: read word is a fixed tag combined with the requested index.
   assign xd_word_i = 64'hDEAD_BEEF_0000_0000 | {60'd0, xd_word_index_o};
   assign all_out = {cmd_ready_o, din_ready_o, dout_valid_o, dout_data_o, xd_init_o, xd_start_o,
                     xd_word_enable_o, xd_domain_enable_o, xd_rdi_valid_o, xd_word_o,
                     xd_word_index_o, xd_domain_o, busy_o, err_o};

   xoodoo_sca_ctrl #(.NWORDS(NWORDS), .TIMEOUT(TIMEOUT)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o), .cmd_flags_i(cmd_flags),
      .cmd_domain_i(cmd_domain), .cmd_dom_en_i(cmd_dom_en),
      .din_valid_i(din_valid), .din_ready_o(din_ready_o), .din_data_i(din_data),
      .dout_valid_o(dout_valid_o), .dout_ready_i(dout_ready), .dout_data_o(dout_data_o),
      .rnd_valid_i(rnd_valid),
      .xd_init_o(xd_init_o), .xd_start_o(xd_start_o), .xd_word_enable_o(xd_word_enable_o),
      .xd_domain_enable_o(xd_domain_enable_o), .xd_rdi_valid_o(xd_rdi_valid_o),
      .xd_word_o(xd_word_o), .xd_word_index_o(xd_word_index_o), .xd_domain_o(xd_domain_o),
      .xd_word_i(xd_word_i), .xd_state_valid_i(xd_state_valid), .xd_rdi_ready_i(xd_rdi_ready),
      .busy_o(busy_o), .err_o(err_o)
   );

   function automatic logic [63:0] load_word(input int i);
      return {32'h5A00_0000 + 32'(i), 32'hA500_0000 + 32'(i)};
   endfunction

   function automatic logic [63:0] read_word(input int i);
      return 64'hDEAD_BEEF_0000_0000 | 64'(i);
   endfunction

   task automatic idle_inputs();
      cmd_valid = 0; cmd_flags = 0; cmd_domain = 0; cmd_dom_en = 0;
      din_valid = 0; din_data = 0; dout_ready = 0; rnd_valid = 0;
      xd_state_valid = 0; xd_rdi_ready = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 0;
      idle_inputs();
      repeat (2) @(negedge clk);
      rst_n = 1;
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] flags, input logic de, input logic [31:0] dom);
      @(negedge clk);
      cmd_valid = 1; cmd_flags = flags; cmd_dom_en = de; cmd_domain = dom;
      #1;
      checks++;
      if (cmd_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL cmd_accept: cmd_ready_o=%b expected 1", cmd_ready_o);
      end
      @(posedge clk);
      #1;
      cmd_valid = 0; cmd_flags = 0; cmd_dom_en = 0; cmd_domain = 0;
   endtask

   task automatic test_reset();
      rst_n = 0;
      idle_inputs();
      #12;
      checks++;
      if (all_out !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %h expected 0", all_out);
      end
      @(negedge clk);
      rst_n = 1;
      #1;
      checks++;
      if (cmd_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL ready_before_edge: cmd_ready_o=%b expected 0", cmd_ready_o);
      end
      @(negedge clk);
      #1;
      checks++;
      if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL ready_after_release: cmd_ready_o=%b busy_o=%b expected 1/0", cmd_ready_o, busy_o);
      end
   endtask

   task automatic test_full();
      int n_init = 0, n_words = 0, n_dom = 0, n_start = 0, n_read = 0, run_cnt = 0;
      bit started = 0, done = 0;
      logic [31:0] dom_seen = '0;
      issue(4'b1111, 1'b1, 32'h0000_0001);
      rnd_valid = 1; dout_ready = 1; xd_rdi_ready = 1;
      for (int c = 0; c < 200 && !done; c++) begin
         @(negedge clk);
         din_valid = (c % 3) != 1;
         din_data  = load_word(n_words);
         if (started) run_cnt++;
         xd_state_valid = started && (run_cnt == 12);
         #1;
         if (xd_init_o) n_init++;
         if (xd_word_enable_o) begin
            checks++;
            if (xd_word_index_o !== 4'(n_words) || xd_word_o !== load_word(n_words)) begin
               errors++;
               $display("FAIL full_load_%0d: index %0d word %h expected index %0d word %h",
                        n_words, xd_word_index_o, xd_word_o, n_words, load_word(n_words));
            end
            n_words++;
         end
         if (xd_domain_enable_o) begin n_dom++; dom_seen = xd_domain_o; end
         if (xd_start_o) begin n_start++; started = 1; run_cnt = 0; end
         if (dout_valid_o) begin
            checks++;
            if (xd_word_index_o !== 4'(n_read) || dout_data_o !== read_word(n_read)) begin
               errors++;
               $display("FAIL full_read_%0d: index %0d data %h expected index %0d data %h",
                        n_read, xd_word_index_o, dout_data_o, n_read, read_word(n_read));
            end
            n_read++;
         end
         if (!busy_o) done = 1;
      end
      checks++;
      if (n_init != 1 || n_words != NWORDS || n_dom != 1 || n_start != 1 || n_read != NWORDS) begin
         errors++;
         $display("FAIL full_counts: init %0d words %0d dom %0d start %0d read %0d expected 1 12 1 1 12",
                  n_init, n_words, n_dom, n_start, n_read);
      end
      checks++;
      if (dom_seen !== 32'h1) begin
         errors++;
         $display("FAIL full_domain: got %h expected 00000001", dom_seen);
      end
      checks++;
      if (!done || cmd_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL full_idle: done=%0d cmd_ready_o=%b expected 1/1", done, cmd_ready_o);
      end
      idle_inputs();
   endtask

   task automatic test_flags_zero();
      bit seen = 0;
      issue(4'b0000, 1'b1, 32'hFFFF_FFFF);
      repeat (3) begin
         @(negedge clk);
         #1;
         if (busy_o || xd_init_o || xd_word_enable_o || xd_domain_enable_o || xd_start_o ||
             din_ready_o || dout_valid_o) seen = 1;
      end
      checks++;
      if (seen || cmd_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL flags_zero: activity=%0d cmd_ready_o=%b expected 0/1", seen, cmd_ready_o);
      end
   endtask

   task automatic test_arm_wait();
      bit early = 0;
      issue(4'b0100, 1'b0, 32'h0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         rnd_valid = 0;
         #1;
         if (xd_start_o || xd_rdi_valid_o || !busy_o) early = 1;
      end
      checks++;
      if (early) begin
         errors++;
         $display("FAIL arm_early_start: start/rdi_valid seen while rnd_valid=0, expected none");
      end
      @(negedge clk);
      rnd_valid = 1;
      #1;
      checks++;
      if (xd_start_o !== 1'b1 || xd_rdi_valid_o !== 1'b1) begin
         errors++;
         $display("FAIL arm_start: start=%b rdi_valid=%b expected 1/1", xd_start_o, xd_rdi_valid_o);
      end
      @(negedge clk);
      xd_state_valid = 1;
      #1;
      checks++;
      if (xd_start_o !== 1'b0 || busy_o !== 1'b1) begin
         errors++;
         $display("FAIL arm_run: start=%b busy=%b expected 0/1", xd_start_o, busy_o);
      end
      @(negedge clk);
      xd_state_valid = 0; rnd_valid = 0;
      #1;
      checks++;
      if (busy_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL arm_done_idle: busy=%b cmd_ready=%b expected 0/1", busy_o, cmd_ready_o);
      end
   endtask

   task automatic test_rdi_error();
      bit ready_seen = 0;
      issue(4'b0100, 1'b0, 32'h0);
      rnd_valid = 1; xd_rdi_ready = 1;
      @(negedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (err_o !== 1'b0) begin
         errors++;
         $display("FAIL rdi_no_err: err_o=%b expected 0", err_o);
      end
      @(negedge clk);
      rnd_valid = 0;
      #1;
      checks++;
      if (err_o !== 1'b0 || xd_rdi_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL rdi_drop_cycle: err_o=%b rdi_valid=%b expected 0/0", err_o, xd_rdi_valid_o);
      end
      @(negedge clk);
      rnd_valid = 1;
      #1;
      checks++;
      if (err_o !== 1'b1 || busy_o !== 1'b1 || cmd_ready_o !== 1'b0 || xd_rdi_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL rdi_err: err=%b busy=%b cmd_ready=%b rdi_valid=%b expected 1/1/0/0",
                  err_o, busy_o, cmd_ready_o, xd_rdi_valid_o);
      end
      cmd_valid = 1; cmd_flags = 4'b1111;
      repeat (3) begin
         @(negedge clk);
         #1;
         if (cmd_ready_o || !err_o || xd_init_o) ready_seen = 1;
      end
      checks++;
      if (ready_seen) begin
         errors++;
         $display("FAIL err_sticky: ERR left or command taken, expected sticky ERR");
      end
      do_reset();
      checks++;
      if (err_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL err_cleared: err=%b cmd_ready=%b expected 0/1", err_o, cmd_ready_o);
      end
   endtask

   task automatic test_timeout();
      int first_err = 0;
      issue(4'b0100, 1'b0, 32'h0);
      rnd_valid = 1; xd_rdi_ready = 0;
      @(negedge clk);
      #1;
      checks++;
      if (xd_start_o !== 1'b1) begin
         errors++;
         $display("FAIL timeout_start: start=%b expected 1", xd_start_o);
      end
      for (int i = 1; i <= TIMEOUT + 1 && first_err == 0; i++) begin
         @(negedge clk);
         #1;
         if (err_o) first_err = i;
      end
      checks++;
      if (first_err != TIMEOUT + 1) begin
         errors++;
         $display("FAIL timeout_err: err first seen at RUN cycle %0d expected %0d", first_err, TIMEOUT + 1);
      end
      do_reset();
   endtask

   task automatic test_read_stall();
      int n = 0;
      bit stalled = 0, done = 0;
      logic [3:0]  prev_idx = '0;
      logic [63:0] prev_data = '0;
      issue(4'b1000, 1'b0, 32'h0);
      for (int c = 0; c < 60 && !done; c++) begin
         @(negedge clk);
         dout_ready = (c % 2) == 1;
         #1;
         if (!busy_o) begin
            done = 1;
         end else begin
            if (stalled) begin
               checks++;
               if (xd_word_index_o !== prev_idx || dout_data_o !== prev_data) begin
                  errors++;
                  $display("FAIL stall_hold: index %0d data %h expected index %0d data %h",
                           xd_word_index_o, dout_data_o, prev_idx, prev_data);
               end
            end
            if (dout_valid_o && dout_ready) begin
               checks++;
               if (xd_word_index_o !== 4'(n) || dout_data_o !== read_word(n)) begin
                  errors++;
                  $display("FAIL stall_xfer_%0d: index %0d data %h expected index %0d data %h",
                           n, xd_word_index_o, dout_data_o, n, read_word(n));
               end
               n++;
               stalled = 0;
            end else if (dout_valid_o) begin
               stalled = 1; prev_idx = xd_word_index_o; prev_data = dout_data_o;
            end
         end
      end
      checks++;
      if (n != NWORDS || !done) begin
         errors++;
         $display("FAIL stall_count: transfers %0d done=%0d expected 12/1", n, done);
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid_load();
      int n = 0;
      bit bad = 0, done = 0;
      issue(4'b0010, 1'b0, 32'h0);
      din_valid = 1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         din_data = load_word(i);
         #1;
         if (xd_word_index_o !== 4'(i) || !xd_word_enable_o) bad = 1;
      end
      @(negedge clk);
      din_data = load_word(5);
      #1;
      checks++;
      if (bad || xd_word_index_o !== 4'd5) begin
         errors++;
         $display("FAIL midload_index: index %0d expected 5 (earlier bad=%0d)", xd_word_index_o, bad);
      end
      rst_n = 0;
      #1;
      checks++;
      if (all_out !== '0) begin
         errors++;
         $display("FAIL midload_reset_outputs: got %h expected 0", all_out);
      end
      @(negedge clk);
      rst_n = 1;
      issue(4'b0010, 1'b0, 32'h0);
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         din_data = load_word(n);
         #1;
         if (!busy_o) begin
            done = 1;
         end else if (xd_word_enable_o) begin
            checks++;
            if (xd_word_index_o !== 4'(n)) begin
               errors++;
               $display("FAIL reload_index_%0d: index %0d expected %0d", n, xd_word_index_o, n);
            end
            n++;
         end
      end
      checks++;
      if (n != NWORDS || !done) begin
         errors++;
         $display("FAIL reload_count: words %0d done=%0d expected 12/1", n, done);
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_full();
      test_flags_zero();
      test_arm_wait();
      test_rdi_error();
      test_timeout();
      test_read_stall();
      test_reset_mid_load();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end
endmodule
